sprite_layer_ctrl: RTL and testbench

- Parametrised sprite register file and per-pixel hit/priority compositor for the VGA pipeline, running on the 25 MHz pixel clock between the processor and the vgamult renderer.
- Generalises the single sprite_x/sprite_y/sprite_vis/sprite_sel channel to NUM_SPRITES channels.
- Double-buffers each channel (pending/active) so updates commit only at frame boundary, with no tearing.
- Drives the processor interrupt vector (vblank, sprite collision) that is currently tied off.

---
 rtl/sprite_layer_ctrl.sv | 176 +++++++++++++++++
 tb/tb_sprite_layer_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sprite_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : sprite_layer_ctrl
//  Brief    : Multi-channel sprite register file with double-buffered
//             commit at frame start, per-pixel hit test, lowest-index
//             priority compositor, collision tracking and interrupts.
//  Revision : 1.0 - initial release
// ============================================================================
module sprite_layer_ctrl #(
    parameter int NUM_SPRITES = 4,
    parameter int IDX_W       = 2,
    parameter int SPR_W       = 32,
    parameter int SPR_H       = 32
) (
    input  logic                   clk_25mhz,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic [IDX_W-1:0]       wr_idx,
    input  logic [9:0]             wr_x,
    input  logic [8:0]             wr_y,
    input  logic                   wr_vis,
    input  logic [4:0]             wr_sel,
    input  logic                   frame_start,
    input  logic                   pix_active,
    input  logic [9:0]             pix_x,
    input  logic [8:0]             pix_y,
    input  logic [3:0]             irq_ack,
    output logic                   hit,
    output logic [IDX_W-1:0]       hit_idx,
    output logic [4:0]             hit_sel,
    output logic [4:0]             hit_dx,
    output logic [4:0]             hit_dy,
    output logic [NUM_SPRITES-1:0] coll_mask,
    output logic [3:0]             irq
);

    // Channel count widened by one bit so out-of-range indices compare cleanly.
    localparam logic [IDX_W:0] c_num_spr = (IDX_W+1)'(NUM_SPRITES);
    // Extents widened by one bit so far-right/bottom sprites clip instead of wrapping.
    localparam logic [10:0]    c_spr_w   = 11'(SPR_W);
    localparam logic [9:0]     c_spr_h   = 10'(SPR_H);

    logic [9:0] r_pend_x   [NUM_SPRITES];
    logic [8:0] r_pend_y   [NUM_SPRITES];
    logic       r_pend_vis [NUM_SPRITES];
    logic [4:0] r_pend_sel [NUM_SPRITES];
    logic [9:0] r_act_x    [NUM_SPRITES];
    logic [8:0] r_act_y    [NUM_SPRITES];
    logic       r_act_vis  [NUM_SPRITES];
    logic [4:0] r_act_sel  [NUM_SPRITES];

    logic [NUM_SPRITES-1:0] w_cover;
    logic [NUM_SPRITES-1:0] w_contrib;
    logic [NUM_SPRITES-1:0] w_coll_next;
    logic                   w_multi;
    logic                   w_coll_set;
    logic                   w_any;
    logic [IDX_W-1:0]       w_win_idx;
    logic [4:0]             w_win_sel;
    logic [4:0]             w_win_dx;
    logic [4:0]             w_win_dy;
    logic [NUM_SPRITES-1:0] r_coll_live;
    logic [1:0]             r_irq;
    logic                   w_unused_ack;

    // Processor writes land in pending; pending is copied to active at frame start.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_SPRITES; i++) begin
                r_pend_x[i]   <= '0;
                r_pend_y[i]   <= '0;
                r_pend_vis[i] <= 1'b0;
                r_pend_sel[i] <= '0;
                r_act_x[i]    <= '0;
                r_act_y[i]    <= '0;
                r_act_vis[i]  <= 1'b0;
                r_act_sel[i]  <= '0;
            end
        end else begin
            if (frame_start) begin
                for (int i = 0; i < NUM_SPRITES; i++) begin
                    r_act_x[i]   <= r_pend_x[i];
                    r_act_y[i]   <= r_pend_y[i];
                    r_act_vis[i] <= r_pend_vis[i];
                    r_act_sel[i] <= r_pend_sel[i];
                end
            end
            if (wr_en && ({1'b0, wr_idx} < c_num_spr)) begin
                r_pend_x[wr_idx]   <= wr_x;
                r_pend_y[wr_idx]   <= wr_y;
                r_pend_vis[wr_idx] <= wr_vis;
                r_pend_sel[wr_idx] <= wr_sel;
            end
        end
    end

    generate
        for (genvar g = 0; g < NUM_SPRITES; g++) begin : g_cover
            assign w_cover[g] = pix_active & r_act_vis[g]
                              & (pix_x >= r_act_x[g])
                              & ({1'b0, pix_x} < ({1'b0, r_act_x[g]} + c_spr_w))
                              & (pix_y >= r_act_y[g])
                              & ({1'b0, pix_y} < ({1'b0, r_act_y[g]} + c_spr_h));
        end
    endgenerate

    // Lowest covering index wins; scan downward so the last assignment is the lowest.
    always_comb begin
        w_any     = 1'b0;
        w_win_idx = '0;
        w_win_sel = '0;
        w_win_dx  = '0;
        w_win_dy  = '0;
        for (int i = NUM_SPRITES - 1; i >= 0; i--) begin
            if (w_cover[i]) begin
                w_any     = 1'b1;
                w_win_idx = IDX_W'(i);
                w_win_sel = r_act_sel[i];
                // Only the low bits of the offset are needed; they depend only on low bits.
                w_win_dx  = pix_x[4:0] - r_act_x[i][4:0];
                w_win_dy  = pix_y[4:0] - r_act_y[i][4:0];
            end
        end
    end

    // A vector with two or more bits set still has bits left after clearing its lowest.
    assign w_multi     = |(w_cover & (w_cover - 1'b1));
    assign w_contrib   = w_multi ? w_cover : '0;
    assign w_coll_next = r_coll_live | w_contrib;
    assign w_coll_set  = frame_start & (|w_coll_next);

    // Compositor outputs are registered: one cycle from pixel in to result out.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            hit     <= 1'b0;
            hit_idx <= '0;
            hit_sel <= '0;
            hit_dx  <= '0;
            hit_dy  <= '0;
        end else begin
            hit     <= w_any;
            hit_idx <= w_win_idx;
            hit_sel <= w_win_sel;
            hit_dx  <= w_win_dx;
            hit_dy  <= w_win_dy;
        end
    end

    // Collisions accumulate across a frame and are published at frame start.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            r_coll_live <= '0;
            coll_mask   <= '0;
        end else if (frame_start) begin
            coll_mask   <= w_coll_next;
            r_coll_live <= '0;
        end else begin
            r_coll_live <= w_coll_next;
        end
    end

    // Sticky interrupts; a set on the same cycle as an ack takes precedence.
    always_ff @(posedge clk_25mhz or posedge rst) begin
        if (rst) begin
            r_irq <= '0;
        end else begin
            r_irq[0] <= frame_start | (r_irq[0] & ~irq_ack[0]);
            r_irq[1] <= w_coll_set  | (r_irq[1] & ~irq_ack[1]);
        end
    end

    assign irq          = {2'b00, r_irq};
    assign w_unused_ack = ^irq_ack[3:2];

endmodule
`default_nettype wire

// File: tb/tb_sprite_layer_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sprite_layer_ctrl
//  Brief    : Self-checking bench for sprite_layer_ctrl: directed scenarios
//             with literal expectations plus randomized traffic compared
//             every cycle against a behavioural sprite model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_sprite_layer_ctrl;

    localparam int NS    = 3;
    localparam int IW    = 2;
    localparam int SPR_W = 32;
    localparam int SPR_H = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic [IW-1:0] wr_idx;
    logic [9:0]    wr_x;
    logic [8:0]    wr_y;
    logic          wr_vis;
    logic [4:0]    wr_sel;
    logic          frame_start;
    logic          pix_active;
    logic [9:0]    pix_x;
    logic [8:0]    pix_y;
    logic [3:0]    irq_ack;
    logic          hit;
    logic [IW-1:0] hit_idx;
    logic [4:0]    hit_sel;
    logic [4:0]    hit_dx;
    logic [4:0]    hit_dy;
    logic [NS-1:0] coll_mask;
    logic [3:0]    irq;

    int checks = 0;
    int errors = 0;
    bit cmp_en = 1'b0;

    sprite_layer_ctrl #(
        .NUM_SPRITES(NS), .IDX_W(IW), .SPR_W(SPR_W), .SPR_H(SPR_H)
    ) dut (
        .clk_25mhz(clk), .rst(rst), .wr_en(wr_en), .wr_idx(wr_idx),
        .wr_x(wr_x), .wr_y(wr_y), .wr_vis(wr_vis), .wr_sel(wr_sel),
        .frame_start(frame_start), .pix_active(pix_active),
        .pix_x(pix_x), .pix_y(pix_y), .irq_ack(irq_ack),
        .hit(hit), .hit_idx(hit_idx), .hit_sel(hit_sel),
        .hit_dx(hit_dx), .hit_dy(hit_dy), .coll_mask(coll_mask), .irq(irq)
    );

    always #20 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int x;
        int y;
        bit vis;
        int sel;
    } spr_t;

    spr_t          m_pend [NS];
    spr_t          m_act  [NS];
    bit   [NS-1:0] m_live;
    logic          exp_hit;
    logic [IW-1:0] exp_idx;
    logic [4:0]    exp_sel;
    logic [4:0]    exp_dx;
    logic [4:0]    exp_dy;
    logic [NS-1:0] exp_coll;
    logic [3:0]    exp_irq;

    always @(posedge clk or posedge rst) begin : model
        bit [NS-1:0] cov;
        bit [NS-1:0] contrib;
        int n;
        int w;
        int px;
        int py;
        if (rst) begin
            for (int i = 0; i < NS; i++) begin
                m_pend[i] <= '{0, 0, 1'b0, 0};
                m_act[i]  <= '{0, 0, 1'b0, 0};
            end
            m_live   <= '0;
            exp_hit  <= 1'b0;
            exp_idx  <= '0;
            exp_sel  <= '0;
            exp_dx   <= '0;
            exp_dy   <= '0;
            exp_coll <= '0;
            exp_irq  <= '0;
        end else begin
            px = int'(pix_x);
            py = int'(pix_y);
            cov = '0;
            n = 0;
            w = -1;
            for (int i = 0; i < NS; i++) begin
                if (pix_active && m_act[i].vis &&
                    px >= m_act[i].x && px < m_act[i].x + SPR_W &&
                    py >= m_act[i].y && py < m_act[i].y + SPR_H) begin
                    cov[i] = 1'b1;
                    n++;
                    if (w < 0) w = i;
                end
            end
            if (w >= 0) begin
                exp_hit <= 1'b1;
                exp_idx <= IW'(w);
                exp_sel <= 5'(m_act[w].sel);
                exp_dx  <= 5'(px - m_act[w].x);
                exp_dy  <= 5'(py - m_act[w].y);
            end else begin
                exp_hit <= 1'b0;
                exp_idx <= '0;
                exp_sel <= '0;
                exp_dx  <= '0;
                exp_dy  <= '0;
            end
            contrib = (n >= 2) ? cov : '0;
            if (frame_start) begin
                exp_coll <= m_live | contrib;
                m_live   <= '0;
                for (int i = 0; i < NS; i++) m_act[i] <= m_pend[i];
            end else begin
                m_live <= m_live | contrib;
            end
            exp_irq[0] <= frame_start | (exp_irq[0] & ~irq_ack[0]);
            exp_irq[1] <= (frame_start && ((m_live | contrib) != 0)) | (exp_irq[1] & ~irq_ack[1]);
            exp_irq[3:2] <= 2'b00;
            if (wr_en && int'(wr_idx) < NS)
                m_pend[wr_idx] <= '{int'(wr_x), int'(wr_y), wr_vis, int'(wr_sel)};
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_hit",  32'(hit),       32'(exp_hit));
            chk("m_idx",  32'(hit_idx),   32'(exp_idx));
            chk("m_sel",  32'(hit_sel),   32'(exp_sel));
            chk("m_dx",   32'(hit_dx),    32'(exp_dx));
            chk("m_dy",   32'(hit_dy),    32'(exp_dy));
            chk("m_coll", 32'(coll_mask), 32'(exp_coll));
            chk("m_irq",  32'(irq),       32'(exp_irq));
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int idx, input int x, input int y, input bit v, input int s);
        wr_en = 1'b1; wr_idx = IW'(idx); wr_x = 10'(x); wr_y = 9'(y);
        wr_vis = v; wr_sel = 5'(s);
        cyc();
        wr_en = 1'b0;
    endtask

    task automatic fs();
        frame_start = 1'b1;
        cyc();
        frame_start = 1'b0;
    endtask

    task automatic px(input int x, input int y);
        pix_active = 1'b1; pix_x = 10'(x); pix_y = 9'(y);
        cyc();
        pix_active = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_idx = '0; wr_x = '0; wr_y = '0;
        wr_vis = 1'b0; wr_sel = '0; frame_start = 1'b0; pix_active = 1'b0;
        pix_x = '0; pix_y = '0; irq_ack = '0;
        cyc();
        cmp_en = 1'b1;
        cyc();
        chk("rst_hit", 32'(hit), 0);
        chk("rst_irq", 32'(irq), 0);
        chk("rst_coll", 32'(coll_mask), 0);
        rst = 1'b0;

        // Scenario 1: commit only at frame start; corner and just-outside pixels.
        wr(0, 100, 50, 1'b1, 3);
        px(100, 50);   chk("s1_precommit_hit", 32'(hit), 0);
        fs();          chk("s1_irq_vblank", 32'(irq), 32'h1);
        px(100, 50);
        chk("s1_hit", 32'(hit), 1); chk("s1_idx", 32'(hit_idx), 0);
        chk("s1_sel", 32'(hit_sel), 3);
        chk("s1_dx", 32'(hit_dx), 0); chk("s1_dy", 32'(hit_dy), 0);
        px(131, 81);
        chk("s1_far_hit", 32'(hit), 1);
        chk("s1_far_dx", 32'(hit_dx), 31); chk("s1_far_dy", 32'(hit_dy), 31);
        px(132, 50);   chk("s1_out_hit", 32'(hit), 0);

        // Scenario 2: priority and collision reporting.
        wr(0, 100, 50, 1'b0, 3);
        wr(1, 110, 60, 1'b1, 7);
        wr(2, 110, 60, 1'b1, 9);
        fs();
        px(115, 65);
        chk("s2_idx", 32'(hit_idx), 1); chk("s2_sel", 32'(hit_sel), 7);
        chk("s2_dx", 32'(hit_dx), 5);
        fs();
        chk("s2_coll", 32'(coll_mask), 32'b110);
        chk("s2_irq", 32'(irq), 32'b0011);

        // Scenario 3: right/bottom clipping, no wrap to column/row 0.
        wr(1, 0, 0, 1'b0, 0);
        wr(2, 0, 0, 1'b0, 0);
        wr(0, 620, 470, 1'b1, 1);
        fs();
        chk("s3_coll_clear", 32'(coll_mask), 0);
        px(639, 479);
        chk("s3_hit", 32'(hit), 1);
        chk("s3_dx", 32'(hit_dx), 19); chk("s3_dy", 32'(hit_dy), 9);
        px(0, 470);    chk("s3_nowrap_x", 32'(hit), 0);
        px(5, 0);      chk("s3_nowrap_y", 32'(hit), 0);

        // Scenario 4: set beats ack on the same cycle, ack alone clears.
        irq_ack = 4'b0001;
        fs();          chk("s4_set_wins", 32'(irq[0]), 1);
        cyc();         chk("s4_ack", 32'(irq[0]), 0);
        irq_ack = 4'b0000;

        // Scenario 5: out-of-range write ignored; write coincident with frame start deferred.
        wr(3, 0, 0, 1'b1, 5);
        fs();
        px(0, 0);      chk("s5_oob_ignored", 32'(hit), 0);
        wr_en = 1'b1; wr_idx = 2'd0; wr_x = 10'd200; wr_y = 9'd200; wr_vis = 1'b1;
        wr_sel = 5'd2; frame_start = 1'b1;
        cyc();
        wr_en = 1'b0; frame_start = 1'b0;
        px(200, 200);  chk("s5_deferred", 32'(hit), 0);
        fs();
        px(200, 200);
        chk("s5_after_hit", 32'(hit), 1); chk("s5_after_sel", 32'(hit_sel), 2);
        chk("s5_irq", 32'(irq), 32'b0011);

        // Scenario 6: asynchronous reset mid-frame.
        rst = 1'b1;
        #1;
        chk("s6_async_hit", 32'(hit), 0);
        chk("s6_async_sel", 32'(hit_sel), 0);
        chk("s6_async_irq", 32'(irq), 0);
        cyc();
        rst = 1'b0;
        wr(0, 200, 200, 1'b1, 2);
        fs();
        pix_active = 1'b0; pix_x = 10'd200; pix_y = 9'd200;
        cyc();         chk("s6_inactive", 32'(hit), 0);
        px(200, 200);  chk("s6_commit_after_rst", 32'(hit), 1);

        // Randomized traffic, checked every cycle by the model comparison.
        for (int c = 0; c < 4000; c++) begin
            wr_en = ($urandom_range(0, 5) == 0);
            wr_idx = IW'($urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) begin
                wr_x = 10'($urandom_range(990, 1023));
                wr_y = 9'($urandom_range(480, 511));
            end else begin
                wr_x = 10'($urandom_range(0, 200));
                wr_y = 9'($urandom_range(0, 150));
            end
            wr_vis = ($urandom_range(0, 3) != 0);
            wr_sel = 5'($urandom);
            frame_start = ($urandom_range(0, 40) == 0);
            pix_active = ($urandom_range(0, 5) != 0);
            if ($urandom_range(0, 9) == 0) begin
                pix_x = 10'($urandom_range(980, 1023));
                pix_y = 9'($urandom_range(470, 511));
            end else begin
                pix_x = 10'($urandom_range(0, 250));
                pix_y = 9'($urandom_range(0, 200));
            end
            irq_ack = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'b0000;
            if ($urandom_range(0, 999) == 0) begin
                rst = 1'b1;
                cyc();
                rst = 1'b0;
            end
            cyc();
        end

        cmp_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
